// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU.
//   op_e    : operation encodings carried on the 3-bit op port
//   state_t : control state (StIdle, StMulRun); StMulRun is only used
//             when ALU_MC_MUL_EN is defined
package alu_mc_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpShl = 3'd5,
    OpShr = 3'd6,
    OpMul = 3'd7
  } op_e;

  typedef logic [0:0] state_t;
  localparam state_t StIdle   = 1'b0;
  localparam state_t StMulRun = 1'b1;

endpackage

// File: rtl/alu_mc_shift.sv
// Combinational zero-filling barrel shifter for SHL/SHR.
//   a_i     : value to shift
//   shamt_i : shift amount
//   right_i : 1 = shift right, 0 = shift left
//   res_o   : shifted value
//   carry_o : last bit shifted out (0 for a zero shift)
module alu_mc_shift
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic             right_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o
);

  // One guard bit beside the operand catches the last bit to leave it.
  logic [WIDTH:0] left_ext;
  logic [WIDTH:0] right_ext;

  assign left_ext  = {1'b0, a_i} << shamt_i;
  assign right_ext = {a_i, 1'b0} >> shamt_i;

  always_comb begin
    if (right_i) begin
      res_o   = right_ext[WIDTH:1];
      carry_o = right_ext[0];
    end else begin
      res_o   = left_ext[WIDTH-1:0];
      carry_o = left_ext[WIDTH];
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with operand registers and a shared output bus.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   bus_in, rega/regb_write_enable : operand loads (reg_a wins if both set)
//   start, op, shift_pos       : operation request (ignored while busy)
//   alu/hi/rega/regb_enable    : bus_out source selects, in priority order
//   bus_out                    : selected value, all ones when nothing selected
//   busy, done                 : multiply in progress, one-cycle completion pulse
//   carry_out, zero_out, err   : flags of the last completed operation
// Macro ALU_MC_MUL_EN enables the iterative shift-add multiplier; without it
// op=7 completes at once with err=1 and leaves result, hi and flags untouched.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             rega_write_enable,
  input  logic             regb_write_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   shift_pos,
  input  logic             alu_enable,
  input  logic             hi_enable,
  input  logic             rega_enable,
  input  logic             regb_enable,
  output logic [WIDTH-1:0] bus_out,
  output logic             busy,
  output logic             done,
  output logic             carry_out,
  output logic             zero_out,
  output logic             err
);

  localparam logic [WIDTH:0] One = {{WIDTH{1'b0}}, 1'b1};

  op_e              op_sel;
  logic [WIDTH-1:0] reg_a_q, reg_b_q;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             carry_q, carry_d, zero_q, zero_d, done_q, done_d;
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] alu_res, shift_res;
  logic             alu_carry, shift_carry;
  logic             accept;

  assign op_sel = op_e'(op);
  assign accept = start && !busy;

  // reg_a has priority when both write enables are raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
    end else if (rega_write_enable) begin
      reg_a_q <= bus_in;
    end else if (regb_write_enable) begin
      reg_b_q <= bus_in;
    end
  end

  assign add_sum = {1'b0, reg_a_q} + {1'b0, reg_b_q};
  assign sub_sum = {1'b0, reg_a_q} + {1'b0, ~reg_b_q} + One;

  alu_mc_shift #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .a_i     (reg_a_q),
    .shamt_i (shift_pos),
    .right_i (op_sel == OpShr),
    .res_o   (shift_res),
    .carry_o (shift_carry)
  );

  always_comb begin
    alu_res   = result_q;
    alu_carry = 1'b0;
    case (op_sel)
      OpAdd:   {alu_carry, alu_res} = add_sum;
      OpSub:   {alu_carry, alu_res} = sub_sum;
      OpAnd:   alu_res = reg_a_q & reg_b_q;
      OpOr:    alu_res = reg_a_q | reg_b_q;
      OpXor:   alu_res = reg_a_q ^ reg_b_q;
      OpShl,
      OpShr: begin
        alu_res   = shift_res;
        alu_carry = shift_carry;
      end
      default: alu_res = result_q;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  localparam int unsigned CntW = $clog2(WIDTH);

  state_t            state_q;
  logic [WIDTH-1:0]  mcand_q;
  // Upper half accumulates partial sums; lower half starts as the multiplier
  // snapshot and is consumed one bit per cycle from the LSB.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH:0]    step_sum;
  logic              mul_finish;

  assign step_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_d      = {step_sum, acc_q[WIDTH-1:1]};
  assign mul_finish = (state_q == StMulRun) && (cnt_q == CntW'(WIDTH - 1));
  assign busy       = (state_q == StMulRun);
  assign err        = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == StIdle) begin
      if (accept && op_sel == OpMul) begin
        state_q <= StMulRun;
        mcand_q <= reg_a_q;
        acc_q   <= {{WIDTH{1'b0}}, reg_b_q};
        cnt_q   <= '0;
      end
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (mul_finish) begin
        state_q <= StIdle;
      end
    end
  end
`else
  logic err_q, err_d;

  assign busy = 1'b0;
  assign err  = err_q;

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = (op_sel == OpMul);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  always_comb begin
    result_d = result_q;
    hi_d     = hi_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (accept) begin
      if (op_sel == OpMul) begin
`ifndef ALU_MC_MUL_EN
        done_d = 1'b1;
`endif
      end else begin
        result_d = alu_res;
        hi_d     = '0;
        carry_d  = alu_carry;
        zero_d   = (alu_res == '0);
        done_d   = 1'b1;
      end
    end
`ifdef ALU_MC_MUL_EN
    if (mul_finish) begin
      result_d = acc_d[WIDTH-1:0];
      hi_d     = acc_d[2*WIDTH-1:WIDTH];
      carry_d  = |acc_d[2*WIDTH-1:WIDTH];
      zero_d   = (acc_d == '0);
      done_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      hi_q     <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      hi_q     <= hi_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    if (alu_enable)       bus_out = result_q;
    else if (hi_enable)   bus_out = hi_q;
    else if (rega_enable) bus_out = reg_a_q;
    else if (regb_enable) bus_out = reg_b_q;
    else                  bus_out = '1;
  end

  assign done      = done_q;
  assign carry_out = carry_q;
  assign zero_out  = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes expected completions computed
// by a plain-arithmetic model; a forked monitor pops and compares on done.
module tb_alu_mc;

  localparam int W = 8;
  localparam longint unsigned MASK = (64'd1 << W) - 1;
`ifdef ALU_MC_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] bus_in = '0;
  logic         rega_write_enable = 1'b0, regb_write_enable = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [2:0]   shift_pos = '0;
  logic         alu_enable = 1'b1, hi_enable = 1'b0, rega_enable = 1'b0, regb_enable = 1'b0;
  logic [W-1:0] bus_out;
  logic         busy, done, carry_out, zero_out, err;

  alu_mc #(.WIDTH(W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus_in            (bus_in),
    .rega_write_enable (rega_write_enable),
    .regb_write_enable (regb_write_enable),
    .start             (start),
    .op                (op),
    .shift_pos         (shift_pos),
    .alu_enable        (alu_enable),
    .hi_enable         (hi_enable),
    .rega_enable       (rega_enable),
    .regb_enable       (regb_enable),
    .bus_out           (bus_out),
    .busy              (busy),
    .done              (done),
    .carry_out         (carry_out),
    .zero_out          (zero_out),
    .err               (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint unsigned res;
    bit              carry;
    bit              zero;
    bit              err;
    int unsigned     due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state
  longint unsigned m_a = 0, m_b = 0, m_res = 0, m_hi = 0;
  bit              m_carry = 0, m_zero = 0, m_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("result", 64'(bus_out), e.res);
          chk("carry_out", 64'(carry_out), 64'(e.carry));
          chk("zero_out", 64'(zero_out), 64'(e.zero));
          chk("err", 64'(err), 64'(e.err));
        end
      end
    end
  endtask

  task automatic write_regs(input longint unsigned a, input longint unsigned b);
    rega_write_enable = 1'b1;
    bus_in = W'(a);
    @(posedge clk); #1;
    rega_write_enable = 1'b0;
    regb_write_enable = 1'b1;
    bus_in = W'(b);
    @(posedge clk); #1;
    regb_write_enable = 1'b0;
    m_a = a & MASK;
    m_b = b & MASK;
  endtask

  // Model the operation from the current operands, queue the expectation and
  // pulse start for one cycle.
  task automatic issue(input int o, input int sh);
    exp_t e;
    longint unsigned full, r, h;
    bit c, z, er;
    r = 0; h = 0; c = 0; z = 0; er = 0;
    case (o)
      0: begin full = m_a + m_b; r = full & MASK; c = bit'((full >> W) & 1); end
      1: begin full = m_a + ((~m_b) & MASK) + 1; r = full & MASK; c = bit'((full >> W) & 1); end
      2: r = m_a & m_b;
      3: r = m_a | m_b;
      4: r = m_a ^ m_b;
      5: begin full = m_a << sh; r = full & MASK; c = bit'((full >> W) & 1); end
      6: begin r = m_a >> sh; c = (sh == 0) ? 1'b0 : bit'((m_a >> (sh - 1)) & 1); end
      default: begin
        if (MulEn) begin
          full = m_a * m_b;
          r = full & MASK;
          h = full >> W;
          c = (h != 0);
          z = (full == 0);
        end else begin
          r = m_res; h = m_hi; c = m_carry; z = m_zero; er = 1'b1;
        end
      end
    endcase
    if (o != 7) z = (r == 0);
    m_res = r; m_hi = h; m_carry = c; m_zero = z; m_err = er;
    e.res = r; e.carry = c; e.zero = z; e.err = er;
    e.due = cyc + 1 + ((MulEn && o == 7) ? W : 0);
    sb.push_back(e);
    op = 3'(o);
    shift_pos = 3'(sh);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle(input int o);
    repeat ((MulEn && o == 7) ? W + 1 : 1) @(posedge clk);
    #1;
    chk("completion_seen", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic check_bus(input bit ae, input bit he, input bit ra, input bit rb);
    longint unsigned exp;
    alu_enable = ae; hi_enable = he; rega_enable = ra; regb_enable = rb;
    #1;
    exp = ae ? m_res : he ? m_hi : ra ? m_a : rb ? m_b : MASK;
    chk($sformatf("bus_out_sel_%0d%0d%0d%0d", ae, he, ra, rb), 64'(bus_out), exp);
    alu_enable = 1'b1; hi_enable = 1'b0; rega_enable = 1'b0; regb_enable = 1'b0;
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_carry", 64'(carry_out), 64'd0);
    chk("reset_zero", 64'(zero_out), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    check_bus(1, 0, 0, 0);
    check_bus(0, 0, 1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic and shift cases
    write_regs(64'hF0, 64'h20); issue(0, 0); settle(0);
    write_regs(64'h05, 64'h05); issue(1, 0); settle(1);
    write_regs(64'h03, 64'h05); issue(1, 0); settle(1);
    write_regs(64'h81, 64'h00); issue(5, 1); settle(5);
    issue(6, 0); settle(6);
    check_bus(0, 1, 0, 0);

    // Simultaneous write enables load only reg_a
    bus_in = 8'h3C;
    rega_write_enable = 1'b1; regb_write_enable = 1'b1;
    @(posedge clk); #1;
    rega_write_enable = 1'b0; regb_write_enable = 1'b0;
    m_a = 64'h3C;
    check_bus(0, 0, 1, 0);
    check_bus(0, 0, 0, 1);
    check_bus(0, 0, 0, 0);
    check_bus(1, 1, 1, 1);
    check_bus(0, 1, 1, 1);
    check_bus(0, 0, 1, 1);

`ifdef ALU_MC_MUL_EN
    // 0xFF * 0xFF with a second start attempted while busy
    write_regs(64'hFF, 64'hFF);
    issue(7, 0);
    n = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (i == 2) begin op = 3'd0; start = 1'b1; end
      if (i == 3) start = 1'b0;
    end
    chk("mul_busy_cycles", 64'(n), 64'(W));
    @(posedge clk); #1;
    chk("completion_seen", 64'(sb.size()), 64'd0);
    check_bus(0, 1, 0, 0);

    // reg_b overwritten mid-run: product comes from the snapshot
    write_regs(64'h0D, 64'h0B);
    issue(7, 0);
    @(posedge clk); #1;
    regb_write_enable = 1'b1; bus_in = '0;
    @(posedge clk); #1;
    regb_write_enable = 1'b0;
    m_b = 0;
    repeat (W) @(posedge clk);
    #1;
    chk("completion_seen", 64'(sb.size()), 64'd0);
    check_bus(0, 1, 0, 0);
    check_bus(0, 0, 0, 1);

    // Reset pulsed mid-run aborts without a done pulse
    write_regs(64'h37, 64'h5A);
    op = 3'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    m_a = 0; m_b = 0; m_res = 0; m_hi = 0; m_carry = 0; m_zero = 0; m_err = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_carry", 64'(carry_out), 64'd0);
    chk("abort_zero", 64'(zero_out), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    check_bus(1, 0, 0, 0);
    check_bus(0, 1, 0, 0);
    check_bus(0, 0, 1, 0);
    check_bus(0, 0, 0, 1);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("no_done_after_abort", 64'(n), 64'd0);
    @(posedge clk); #1;
`else
    // op=7 without the multiplier: err, result untouched; next legal op clears err
    write_regs(64'h12, 64'h34);
    issue(0, 0); settle(0);
    issue(7, 0); settle(7);
    check_bus(0, 1, 0, 0);
    issue(0, 0); settle(0);
`endif

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      longint unsigned a, b;
      int o, sh;
      a = longint'($urandom) & MASK;
      b = longint'($urandom) & MASK;
      if ($urandom_range(0, 3) == 0) begin
        bus_in = W'(a);
        rega_write_enable = 1'b1; regb_write_enable = 1'b1;
        @(posedge clk); #1;
        rega_write_enable = 1'b0; regb_write_enable = 1'b0;
        m_a = a;
      end else begin
        write_regs(a, b);
      end
      o  = int'($urandom_range(0, 7));
      sh = int'($urandom_range(0, W - 1));
      issue(o, sh);
      settle(o);
      if (i % 8 == 0) begin
        check_bus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        check_bus(0, 1, 0, 0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the datapath width; legal range 4..32.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port bus_in, input, WIDTH bits: operand data from the shared bus.
REQ-006 The block SHALL have ports rega_write_enable and regb_write_enable, input, 1 bit each: load reg_a or reg_b from bus_in.
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle request to begin an operation.
REQ-008 The block SHALL have port op, input, 3 bits, encoded as ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, MUL=7.
REQ-009 The block SHALL have port shift_pos, input, SHW bits: shift amount.
REQ-010 The block SHALL have ports alu_enable, hi_enable, rega_enable and regb_enable, input, 1 bit each: bus_out source selects.
REQ-011 The block SHALL have port bus_out, output, WIDTH bits: selected value.
REQ-012 The block SHALL have ports busy and done, output, 1 bit each: operation in progress, and a one-cycle completion pulse.
REQ-013 The block SHALL have ports carry_out, zero_out and err, output, 1 bit each: flags of the last completed operation.

Function
REQ-014 The block SHALL sample start only when busy=0; start while busy=1 SHALL be ignored.
REQ-015 For non-MUL ops, start sampled at edge k SHALL update result, carry_out and zero_out at edge k, with done=1 for exactly the following cycle and busy staying 0.
REQ-016 ADD SHALL produce result = A+B and carry_out = bit WIDTH of the sum.
REQ-017 SUB SHALL compute A+~B+1, with carry_out=1 meaning no borrow.
REQ-018 AND, OR and XOR SHALL be bitwise, with carry_out=0.
REQ-019 SHL and SHR SHALL shift reg_a by shift_pos, zero-filled; carry_out SHALL be the last bit shifted out, and 0 when shift_pos=0.
REQ-020 MUL SHALL use an iterative shift-add over snapshot copies of A and B through two states, IDLE and MUL_RUN, each started MUL running for exactly WIDTH cycles in MUL_RUN.
REQ-021 For MUL started at edge k, busy SHALL be 1 from edge k to edge k+WIDTH; result (low half) and hi (high half) SHALL update at edge k+WIDTH, then done=1 for one cycle.
REQ-022 For MUL, carry_out SHALL equal |hi.
REQ-023 zero_out SHALL be 1 when result==0, and for MUL when the full 2*WIDTH product==0.
REQ-024 The flags and result SHALL hold until the next operation completes.
REQ-025 Operand writes SHALL be accepted at any time, including during MUL, without affecting an in-flight MUL.
REQ-026 When rega_write_enable and regb_write_enable are both 1, only reg_a SHALL be written.
REQ-027 bus_out priority SHALL be alu_enable (result), then hi_enable (hi), then rega_enable (reg_a), then regb_enable (reg_b), otherwise all ones.
REQ-028 The hi register SHALL be cleared by every completed non-MUL op.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear reg_a, reg_b, result, hi, the snapshot copies and the counter, set carry_out=0, zero_out=0, done=0, busy=0 and err=0, and force the state to IDLE.
REQ-030 Reset during MUL_RUN SHALL abort the multiply, with no done pulse after release.

Configuration
REQ-031 With macro ALU_MC_MUL_EN defined, MUL SHALL behave per REQ-020..022.
REQ-032 Without ALU_MC_MUL_EN, the MUL_RUN state and multiplier SHALL be absent, and op=7 SHALL complete in one cycle with done=1 and err=1, result, hi and flags unchanged.
REQ-033 err SHALL clear on the next legal op, and SHALL be constant 0 when ALU_MC_MUL_EN is defined.

Structure
REQ-034 Package alu_mc_pkg SHALL hold the op encodings as a typedef enum and the state typedef.
REQ-035 Sub-module alu_mc_shift SHALL be the combinational barrel shifter providing SHL/SHR result and carry, parameterised by WIDTH.

Verification
REQ-036 The bench SHALL check ADD with WIDTH=8, A=0xF0, B=0x20, giving result 0x10, carry_out=1, zero_out=0, done one cycle after start.
REQ-037 The bench SHALL check SUB with A=5, B=5, giving result 0x00, carry_out=1, zero_out=1; and A=3, B=5, giving 0xFE, carry_out=0.
REQ-038 The bench SHALL check SHL with A=0x81, shift_pos=1, giving 0x02, carry_out=1; and SHR with shift_pos=0, giving A unchanged, carry_out=0.
REQ-039 The bench SHALL check MUL with A=0xFF, B=0xFF, giving busy for 8 cycles, then result 0x01, hi 0xFE, carry_out=1, and a second start during busy ignored.
REQ-040 The bench SHALL check MUL with a reg_b write of 0x00 mid-run, giving the product of the snapshot operands unaffected; then rst_n pulsed low mid-run giving all outputs 0 and no done.
REQ-041 The bench SHALL check, without ALU_MC_MUL_EN, op=7 giving err=1 and result unchanged, and a following ADD clearing err.
